endgame_banner: RTL and testbench

Sequences the end-of-game "END" banner overlay for the pong VGA pipeline. Sits directly upstream of `display_endgame`. It drives that block's `start_x`/`start_y` anchor, animates the banner (drop-in, then blink), and gates its `display` result into a registered overlay bit for the pixel mux. It also hands the restart request back to game logic as a one-cycle `new_game` pulse.

---
 rtl/pong_pkg.sv | 16 +
 rtl/endgame_banner_if.sv | 28 ++
 rtl/frame_divider.sv | 40 ++++
 rtl/endgame_banner.sv | 125 ++++++++++++
 tb/tb_endgame_banner.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong VGA pipeline.
package pong_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int CHAR_PITCH = 31;

  // End-of-game banner sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DROP  = 2'd1,
    BLINK = 2'd2,
    CLEAR = 2'd3
  } endgame_state_e;

endpackage

// File: rtl/endgame_banner_if.sv
// Handshake/pixel bundle between game logic, scan timing and the banner sequencer.
interface endgame_banner_if;

  logic       frame_tick;
  logic       game_over;
  logic       restart;
  logic [9:0] x;
  logic [9:0] y;
  logic       text_pixel;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       banner_on;
  logic       busy;
  logic       new_game;

  // Driver side: game logic, scan counters and the glyph renderer.
  modport master (
    output frame_tick, game_over, restart, x, y, text_pixel,
    input  start_x, start_y, banner_on, busy, new_game
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, game_over, restart, x, y, text_pixel,
    output start_x, start_y, banner_on, busy, new_game
  );

endinterface

// File: rtl/frame_divider.sv
// Counts frame ticks 0..N-1; wrap_o pulses combinationally on the tick that
// returns the count to 0. clear_i has priority over tick_i.
module frame_divider #(
  parameter int N = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic wrap_o
);

  localparam int           W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap_o = tick_i && !clear_i && (count_q == LAST);

  // Next count: clear, advance on tick, or hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, whatever the block order.
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/endgame_banner.sv
// End-of-game "END" banner sequencer: drops the banner to mid-screen one step
// per frame, blinks it, and hands a restart back to game logic.
module endgame_banner #(
  parameter int H_ACTIVE     = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = pong_pkg::V_ACTIVE,
  parameter int TEXT_W       = 3 * pong_pkg::CHAR_PITCH,
  parameter int TEXT_H       = 40,
  parameter int DROP_STEP    = 4,
  parameter int BLINK_FRAMES = 30
) (
  input logic              clk,
  input logic              rst_n,
  endgame_banner_if.slave  bus
);

  import pong_pkg::*;

  localparam logic [9:0]  START_X  = 10'((H_ACTIVE - TEXT_W) / 2);
  localparam logic [9:0]  Y_TARGET = 10'((V_ACTIVE - TEXT_H) / 2);
  localparam logic [10:0] STEP     = 11'(DROP_STEP);
  localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);

  endgame_state_e state_q, state_d;
  logic [9:0]     start_y_q, start_y_d;
  logic           visible_q, visible_d;
  logic           banner_on_q, banner_on_d;
  logic           new_game;
  logic           blink_clear, blink_tick, blink_wrap;
  logic [10:0]    drop_sum;

  // 11-bit sum so a large step near the bottom cannot wrap past the target.
  assign drop_sum = {1'b0, start_y_q} + STEP;

  frame_divider #(.N(BLINK_FRAMES)) u_blink_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (blink_clear),
    .tick_i  (blink_tick),
    .wrap_o  (blink_wrap)
  );

  // Next-state, anchor, visibility and restart pulse.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d     = state_q;
    start_y_d   = start_y_q;
    visible_d   = visible_q;
    new_game    = 1'b0;
    blink_clear = 1'b0;
    blink_tick  = 1'b0;
    unique case (state_q)
      IDLE: begin
        blink_clear = 1'b1;
        if (bus.game_over) begin
          state_d   = DROP;
          start_y_d = '0;
          visible_d = 1'b1;
        end
      end
      DROP: begin
        // Holding the counter clear here guarantees BLINK starts from 0.
        blink_clear = 1'b1;
        if (bus.frame_tick) begin
          if (drop_sum >= {1'b0, Y_TARGET}) begin
            start_y_d = Y_TARGET;
            state_d   = BLINK;
            visible_d = 1'b1;
          end else begin
            start_y_d = drop_sum[9:0];
          end
        end
      end
      BLINK: begin
        // Restart beats a coincident tick; the blink counter stays frozen.
        if (bus.restart) begin
          state_d   = CLEAR;
          visible_d = 1'b0;
        end else if (bus.frame_tick) begin
          blink_tick = 1'b1;
          if (blink_wrap) begin
            visible_d = ~visible_q;
          end
        end
      end
      CLEAR: begin
        if (bus.frame_tick) begin
          new_game = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overlay gate uses next-state visibility so restart blanks the banner on
  // the very edge that accepts it; pixel latency from x/y/text_pixel stays one.
  always_comb begin
    banner_on_d = bus.text_pixel && visible_d &&
                  ((state_d == DROP) || (state_d == BLINK)) &&
                  (bus.x < H_LIM) && (bus.y < V_LIM);
  end

  // State, anchor, visibility and overlay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_y_q   <= '0;
      visible_q   <= 1'b0;
      banner_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_y_q   <= start_y_d;
      visible_q   <= visible_d;
      banner_on_q <= banner_on_d;
    end
  end

  assign bus.start_x   = START_X;
  assign bus.start_y   = start_y_q;
  assign bus.banner_on = banner_on_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.new_game  = new_game;

endmodule

// File: tb/tb_endgame_banner.sv
// Randomized and directed bench for endgame_banner against a tick-counting model.
module tb_endgame_banner;

  localparam int EXP_START_X = 273;
  localparam int Y_TGT       = 220;
  localparam int STEP        = 4;
  localparam int HALF        = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  endgame_banner_if bus ();

  endgame_banner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the banner position and blink phase follow from tick counts alone.
  typedef enum {M_IDLE, M_DROP, M_BLINK, M_CLEAR} mode_t;
  mode_t mode;
  int    drop_ticks;
  int    blink_ticks;
  int    exp_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_visible();
    case (mode)
      M_DROP:  return 1'b1;
      M_BLINK: return ((blink_ticks / HALF) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mode        = M_IDLE;
    drop_ticks  = 0;
    blink_ticks = 0;
    exp_y       = 0;
  endtask

  task automatic set_inputs(input bit ft, input bit go, input bit rs,
                            input logic [9:0] xx, input logic [9:0] yy, input bit tp);
    bus.frame_tick = ft;
    bus.game_over  = go;
    bus.restart    = rs;
    bus.x          = xx;
    bus.y          = yy;
    bus.text_pixel = tp;
  endtask

  // One clock with the given inputs; checks the pulse before the edge and
  // registered outputs just after it.
  task automatic cycle(input bit ft, input bit go, input bit rs,
                       input logic [9:0] xx, input logic [9:0] yy, input bit tp);
    bit exp_on;
    set_inputs(ft, go, rs, xx, yy, tp);
    @(negedge clk);
    check("new_game", 32'(bus.new_game), 32'(mode == M_CLEAR && ft));
    @(posedge clk);
    case (mode)
      M_IDLE: if (go) begin
        mode       = M_DROP;
        drop_ticks = 0;
        exp_y      = 0;
      end
      M_DROP: if (ft) begin
        drop_ticks++;
        exp_y = (drop_ticks * STEP >= Y_TGT) ? Y_TGT : drop_ticks * STEP;
        if (drop_ticks * STEP >= Y_TGT) begin
          mode        = M_BLINK;
          blink_ticks = 0;
        end
      end
      M_BLINK: begin
        if (rs) mode = M_CLEAR;
        else if (ft) blink_ticks++;
      end
      M_CLEAR: if (ft) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
    exp_on = tp && model_visible() && (mode == M_DROP || mode == M_BLINK) &&
             (int'(xx) < 640) && (int'(yy) < 480);
    #1;
    check("start_y", 32'(bus.start_y), 32'(exp_y));
    check("start_x", 32'(bus.start_x), 32'(EXP_START_X));
    check("busy", 32'(bus.busy), 32'(mode != M_IDLE));
    check("banner_on", 32'(bus.banner_on), 32'(exp_on));
  endtask

  // Asynchronous reset: outputs must clear with no clock edge.
  task automatic do_reset();
    set_inputs(0, 0, 0, 10'd0, 10'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_start_x", 32'(bus.start_x), 32'(EXP_START_X));
    check("rst_start_y", 32'(bus.start_y), 32'd0);
    check("rst_banner_on", 32'(bus.banner_on), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_new_game", 32'(bus.new_game), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input bit rs, input logic [9:0] xx,
                       input logic [9:0] yy, input bit tp);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, rs, xx, yy, tp);
      cycle(0, 0, 0, xx, yy, tp);
    end
  endtask

  initial begin
    set_inputs(0, 0, 0, 10'd0, 10'd0, 1'b0);
    model_reset();
    #3;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'd273, 10'd220, 1'b1);

    // game_over with a coincident tick: drop starts at 0, first step on next tick.
    cycle(1, 1, 0, 10'd273, 10'd220, 1'b1);
    cycle(0, 0, 0, 10'd273, 10'd220, 1'b1);
    ticks(10, 1'b0, 10'd273, 10'd220, 1'b1);
    ticks(1, 1'b1, 10'd273, 10'd220, 1'b1);     // restart during DROP ignored
    ticks(44, 1'b0, 10'd273, 10'd220, 1'b1);    // 55th tick lands in BLINK

    // Blink: off after 30 ticks, on again after 60; game_over ignored.
    cycle(0, 1, 0, 10'd273, 10'd220, 1'b1);
    ticks(62, 1'b0, 10'd273, 10'd220, 1'b1);
    cycle(0, 0, 1, 10'd273, 10'd220, 1'b1);     // restart blanks immediately
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'd273, 10'd220, 1'b1);
    cycle(1, 0, 0, 10'd273, 10'd220, 1'b1);     // new_game, back to IDLE
    cycle(0, 0, 0, 10'd273, 10'd220, 1'b1);
    cycle(1, 0, 0, 10'd273, 10'd220, 1'b1);

    // Final drop tick with restart, then restart with tick in BLINK.
    cycle(0, 1, 0, 10'd300, 10'd230, 1'b1);
    ticks(54, 1'b0, 10'd300, 10'd230, 1'b1);
    cycle(1, 0, 1, 10'd300, 10'd230, 1'b1);
    cycle(1, 0, 1, 10'd300, 10'd230, 1'b1);
    cycle(1, 0, 0, 10'd300, 10'd230, 1'b1);
    cycle(0, 0, 0, 10'd300, 10'd230, 1'b1);

    // Reset mid-drop at start_y = 100, then a fresh drop from 0.
    cycle(0, 1, 0, 10'd639, 10'd479, 1'b1);
    ticks(25, 1'b0, 10'd640, 10'd479, 1'b1);
    check("pre_reset_y", 32'(bus.start_y), 32'd100);
    do_reset();
    cycle(0, 1, 0, 10'd639, 10'd480, 1'b1);
    ticks(3, 1'b0, 10'd639, 10'd479, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 20000; i++) begin
      logic [9:0] rx, ry;
      rx = 10'(($urandom % 2) ? $urandom_range(600, 700) : $urandom_range(0, 1023));
      ry = 10'(($urandom % 2) ? $urandom_range(440, 520) : $urandom_range(0, 1023));
      if ($urandom_range(0, 4999) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 60) == 0,
              rx, ry, ($urandom % 4) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
